// File: rtl/signed_sub_with_overflow_serial_pkg.sv
// Shared types and default sizes for the serial signed subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_W_DEFAULT     = 16;
  localparam int SUB_CHUNK_DEFAULT = 4;

endpackage

// File: rtl/signed_sub_with_overflow_serial_chunk_adder.sv
// CHUNK-bit ripple slice used once per cycle by the serial subtractor.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + (CHUNK + 1)'(cin);

endmodule

// File: rtl/signed_sub_with_overflow_serial.sv
// Serial signed subtractor: diff = a - b, CHUNK bits per cycle, LSB chunk first.
// Optional clamping on overflow is enabled by defining SUB_SATURATE_EN.
module signed_sub_with_overflow_serial
  import sub_serial_pkg::*;
#(
  parameter int W     = SUB_W_DEFAULT,
  parameter int CHUNK = SUB_CHUNK_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         overflow
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  sub_state_t       state;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     res;
  logic             carry;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic [W-1:0]     raw;
  logic [W-1:0]     final_diff;
  logic             final_ovf;

  // Subtraction is a + ~b + 1: op_b holds the inverted subtrahend and carry starts at 1.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .x    (op_a[CHUNK-1:0]),
    .y    (op_b[CHUNK-1:0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  // raw is the result register after this cycle's chunk enters from the MSB side;
  // on the last chunk it is the complete difference.
  always_comb begin
    raw        = (W'(sum) << (W - CHUNK)) | (res >> CHUNK);
    final_ovf  = (sign_a != sign_b) && (raw[W-1] != sign_a);
    final_diff = raw;
`ifdef SUB_SATURATE_EN
    if (final_ovf) begin
      final_diff = sign_a ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= ~b;
            sign_a <= a[W-1];
            sign_b <= b[W-1];
            carry  <= 1'b1;
            cnt    <= '0;
            res    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          res   <= raw;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          // Publishing on the last chunk makes done and the result visible together.
          if (cnt == CW'(N - 1)) begin
            diff     <= final_diff;
            overflow <= final_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sub_with_overflow_serial.sv
// Directed self-checking bench for the serial signed subtractor (16/4 and 4/1 builds).
module tb_signed_sub_with_overflow_serial;

  localparam int N_BIG   = 4;
  localparam int N_SMALL = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        overflow;

  logic        s_start;
  logic [3:0]  s_a;
  logic [3:0]  s_b;
  logic        s_busy;
  logic        s_done;
  logic [3:0]  s_diff;
  logic        s_overflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  signed_sub_with_overflow_serial #(.W(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .overflow (overflow)
  );

  signed_sub_with_overflow_serial #(.W(4), .CHUNK(1)) dut_small (
    .clk      (clk),
    .rst      (rst),
    .start    (s_start),
    .a        (s_a),
    .b        (s_b),
    .busy     (s_busy),
    .done     (s_done),
    .diff     (s_diff),
    .overflow (s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wrapped expectation turned into the clamped value when saturation is built in.
  function automatic logic [15:0] sat16(input logic [15:0] wrap, input logic ovf, input logic sa);
`ifdef SUB_SATURATE_EN
    if (ovf) return sa ? 16'h8000 : 16'h7FFF;
`endif
    return wrap;
  endfunction

  // Reference for the 4-bit build: {overflow, diff}.
  function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    logic       o;
    d = x - y;
    o = (x[3] != y[3]) && (d[3] != x[3]);
`ifdef SUB_SATURATE_EN
    if (o) d = x[3] ? 4'h8 : 4'h7;
`endif
    return {o, d};
  endfunction

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
    end while (!done && cycles < 40);
  endtask

  task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input string name,
                                input logic [15:0] exp_diff, input logic exp_ovf);
    int cyc;
    int bcyc;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcyc);
    check({name, " latency"}, cyc, N_BIG + 1);
    check({name, " busy cycles"}, bcyc, N_BIG);
    check({name, " diff"}, diff, exp_diff);
    check({name, " overflow"}, overflow, exp_ovf);
  endtask

  initial begin
    int cyc;
    int bcyc;
    int done_cnt;
    logic [4:0] m;

    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    s_start  = 1'b0;
    s_a      = '0;
    s_b      = '0;
    rst      = 1'b1;

    vecs[0]  = '{16'd5,    16'd3,    16'd2,    1'b0};
    vecs[1]  = '{16'h8000, 16'd1,    16'h7FFF, 1'b1};
    vecs[2]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
    vecs[3]  = '{16'h0000, 16'h8000, 16'h8000, 1'b1};
    vecs[4]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'd1,    16'hFFFE, 1'b0};
    vecs[6]  = '{16'd100,  16'd200,  16'hFF9C, 1'b0};
    vecs[7]  = '{16'h1234, 16'h1234, 16'h0000, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};
    vecs[9]  = '{16'h8000, 16'h7FFF, 16'h0001, 1'b1};
    vecs[10] = '{16'hABCD, 16'h1357, 16'h9876, 1'b0};

    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset diff", diff, 16'h0);
    check("reset overflow", overflow, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
                     sat16(vecs[i].diff, vecs[i].ovf, vecs[i].a[15]), vecs[i].ovf);
    end

    // New operands and start during RUN must be ignored.
    @(negedge clk);
    a = 16'd10; b = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    a = 16'd100; b = 16'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("ignore start done count", done_cnt, 1);
    check("ignore start diff", diff, 16'd7);

    // Start held through DONE: second operation accepted back-to-back.
    @(negedge clk);
    a = 16'd20; b = 16'd5; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc, bcyc);
    check("b2b first latency", cyc, N_BIG + 1);
    check("b2b first diff", diff, 16'd15);
    a = 16'hFFFD; b = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcyc);
    check("b2b second latency", cyc, N_BIG + 1);
    check("b2b second busy cycles", bcyc, N_BIG);
    check("b2b second diff", diff, 16'hFFF9);
    check("b2b second overflow", overflow, 1'b0);

    // Reset on the second RUN cycle aborts asynchronously.
    @(negedge clk);
    a = 16'h7FFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort diff", diff, 16'h0);
    check("abort overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    apply_stimulus(16'd5, 16'd3, "after abort", 16'd2, 1'b0);

    // Exhaustive sweep on the 4-bit, 1-bit-per-cycle build.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        s_a = 4'(i); s_b = 4'(j); s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!s_done && cyc < 20);
        m = model4(4'(i), 4'(j));
        check($sformatf("small %0d-%0d latency", i, j), cyc, N_SMALL + 1);
        check($sformatf("small %0d-%0d result", i, j), {s_overflow, s_diff}, m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
